// File: rtl/na_dma_scheduler_pkg.sv
// Shared types and helpers for the NA DMA scheduler.
package optimsoc_na_dma_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RETIRE} na_dma_sched_state_t;

  localparam int NA_DMA_TIMEOUT_W = 16;

  // Index width that stays at least one bit for a single-entry table.
  function automatic int clog2_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/na_dma_scheduler_if.sv
// Request-table / initiator side bundle of the NA DMA scheduler.
interface na_dma_scheduler_if #(
  parameter int ENTRIES = 4
);
  import optimsoc_na_dma_pkg::*;

  localparam int IDXW = clog2_width(ENTRIES);

  logic [ENTRIES-1:0] req_valid;
  logic               sel_valid;
  logic [IDXW-1:0]    sel_idx;
  logic               sel_ready;
  logic               done_valid;
  logic [IDXW-1:0]    done_idx;
  logic               retire_valid;
  logic [IDXW-1:0]    retire_idx;
  logic               retire_err;
  logic               busy;
  logic [ENTRIES-1:0] irq;
  logic [ENTRIES-1:0] irq_clear;

  modport master (
    input  req_valid, sel_ready, done_valid, done_idx, irq_clear,
    output sel_valid, sel_idx, retire_valid, retire_idx, retire_err, busy, irq
  );

  modport slave (
    output req_valid, sel_ready, done_valid, done_idx, irq_clear,
    input  sel_valid, sel_idx, retire_valid, retire_idx, retire_err, busy, irq
  );

endinterface

// File: rtl/na_dma_rr_arb.sv
// Combinational round-robin picker: first unmasked request at or after the pointer.
module na_dma_rr_arb
  import optimsoc_na_dma_pkg::*;
#(
  parameter int ENTRIES = 4,
  localparam int IDXW = clog2_width(ENTRIES)
) (
  input  logic [ENTRIES-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  input  logic [ENTRIES-1:0] i_mask,
  output logic [IDXW-1:0]    o_idx,
  output logic               o_found
);

  logic [ENTRIES-1:0] w_eff;
  logic [ENTRIES-1:0] w_rot;

  assign w_eff = i_req & ~i_mask;
  // Rotate so bit 0 is the pointer position; the lowest set bit is then the winner.
  assign w_rot = ENTRIES'({w_eff, w_eff} >> i_ptr);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    int sum;
    o_found = 1'b0;
    o_idx   = '0;
    sum     = 0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        sum = int'(i_ptr) + k;
        if (sum >= ENTRIES) sum = sum - ENTRIES;
        o_found = 1'b1;
        o_idx   = IDXW'(sum);
      end
    end
  end

endmodule

// File: rtl/na_dma_scheduler.sv
// NA DMA scheduler: round-robin grant, one transfer in flight, retire on done or timeout.
// Optional per-entry completion interrupts with OPTIMSOC_NA_DMA_GENIRQ_EN.
module na_dma_scheduler
  import optimsoc_na_dma_pkg::*;
#(
  parameter int ENTRIES        = 4,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int IDXW          = clog2_width(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  na_dma_scheduler_if.master bus
);

  na_dma_sched_state_t         r_state, w_state_nx;
  logic [IDXW-1:0]             r_ptr, w_ptr_nx;
  logic [IDXW-1:0]             r_sel_idx, r_retire_idx;
  logic [ENTRIES-1:0]          r_mask;
  logic [NA_DMA_TIMEOUT_W-1:0] r_cnt;
  logic                        r_sel_valid, r_retire_valid, r_retire_err, r_busy;
  logic [IDXW-1:0]             w_win_idx;
  logic                        w_win_found, w_handshake, w_done_hit, w_timeout;

  na_dma_rr_arb #(.ENTRIES(ENTRIES)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_mask  (r_mask),
    .o_idx   (w_win_idx),
    .o_found (w_win_found)
  );

  // sel_valid is high for the whole GRANT state, so the state alone qualifies the handshake.
  assign w_handshake = (r_state == GRANT) && bus.sel_ready;
  assign w_done_hit  = (r_state == BUSY) && bus.done_valid && (bus.done_idx == r_sel_idx);
  assign w_ptr_nx    = (r_sel_idx == IDXW'(ENTRIES - 1)) ? '0 : r_sel_idx + IDXW'(1);

  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    assign w_timeout = (r_state == BUSY) &&
                       (r_cnt == NA_DMA_TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_win_found) w_state_nx = GRANT;
      GRANT:   if (bus.sel_ready) w_state_nx = BUSY;
      BUSY:    if (w_done_hit || w_timeout) w_state_nx = RETIRE;
      RETIRE:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_sel_idx      <= '0;
      r_retire_idx   <= '0;
      r_mask         <= '0;
      r_cnt          <= '0;
      r_sel_valid    <= 1'b0;
      r_retire_valid <= 1'b0;
      r_retire_err   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_sel_valid    <= (w_state_nx == GRANT);
      r_busy         <= (w_state_nx == GRANT) || (w_state_nx == BUSY);
      r_retire_valid <= (w_state_nx == RETIRE);
      r_retire_err   <= 1'b0;
      r_cnt          <= (r_state == BUSY) ? r_cnt + NA_DMA_TIMEOUT_W'(1) : '0;
      // The retired entry's req_valid is still high for one more arbitration.
      r_mask         <= (r_state == RETIRE) ? (ENTRIES'(1) << r_sel_idx) : '0;
      if (r_state == IDLE && w_win_found) r_sel_idx <= w_win_idx;
      if (w_handshake) r_ptr <= w_ptr_nx;
      if (r_state == BUSY && w_state_nx == RETIRE) begin
        r_retire_idx <= r_sel_idx;
        r_retire_err <= !w_done_hit;
      end
    end
  end

  assign bus.sel_valid    = r_sel_valid;
  assign bus.sel_idx      = r_sel_idx;
  assign bus.retire_valid = r_retire_valid;
  assign bus.retire_idx   = r_retire_idx;
  assign bus.retire_err   = r_retire_err;
  assign bus.busy         = r_busy;

`ifdef OPTIMSOC_NA_DMA_GENIRQ_EN
  logic [ENTRIES-1:0] r_irq, w_irq_set;

  assign w_irq_set = (r_state == RETIRE && !r_retire_err) ? (ENTRIES'(1) << r_retire_idx) : '0;

  // Set takes priority over a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= '0;
    else        r_irq <= (r_irq & ~bus.irq_clear) | w_irq_set;
  end

  assign bus.irq = r_irq;
`else
  logic [ENTRIES-1:0] w_unused_irq_clear;

  assign w_unused_irq_clear = bus.irq_clear;
  assign bus.irq            = '0;
`endif

endmodule

// File: tb/tb_na_dma_scheduler.sv
// Directed self-checking bench for na_dma_scheduler (ENTRIES=4, TIMEOUT_CYCLES=8).
module tb_na_dma_scheduler;

  localparam int ENTRIES = 4;
  localparam int TMO     = 8;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       dv;
    logic [1:0] di;
    logic       e_sv;
    logic [1:0] e_si;
    logic       e_rv;
    logic [1:0] e_ri;
    logic       e_re;
    logic       e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[$];
  logic [3:0] exp_irq;

  na_dma_scheduler_if #(.ENTRIES(ENTRIES)) bus ();

  na_dma_scheduler #(.ENTRIES(ENTRIES), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy, input logic dv, input logic [1:0] di);
    bus.req_valid  = req;
    bus.sel_ready  = rdy;
    bus.done_valid = dv;
    bus.done_idx   = di;
  endtask

  function automatic void add(input logic [3:0] req, input logic rdy, input logic dv,
                              input logic [1:0] di, input logic e_sv, input logic [1:0] e_si,
                              input logic e_rv, input logic [1:0] e_ri, input logic e_re,
                              input logic e_busy);
    vec_t v;
    v.req = req; v.rdy = rdy; v.dv = dv; v.di = di;
    v.e_sv = e_sv; v.e_si = e_si; v.e_rv = e_rv; v.e_ri = e_ri; v.e_re = e_re; v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " sel_valid"},    32'(bus.sel_valid),    0);
    check({tag, " sel_idx"},      32'(bus.sel_idx),      0);
    check({tag, " retire_valid"}, 32'(bus.retire_valid), 0);
    check({tag, " retire_idx"},   32'(bus.retire_idx),   0);
    check({tag, " retire_err"},   32'(bus.retire_err),   0);
    check({tag, " busy"},         32'(bus.busy),         0);
    check({tag, " irq"},          32'(bus.irq),          0);
  endtask

  initial begin
`ifdef OPTIMSOC_NA_DMA_GENIRQ_EN
    exp_irq = 4'b1000;
`else
    exp_irq = 4'b0000;
`endif
    rst_n = 1'b0;
    bus.irq_clear = '0;
    drive(4'b0000, 1'b0, 1'b0, 2'd0);
    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    //   req      rdy  dv  di     sv  si     rv  ri     re  busy
    // two armed entries: grant 0, retire, grant 2, retire
    add(4'b0101, 1, 0, 2'd0,  1, 2'd0,  0, 2'd0,  0, 1);
    add(4'b0101, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 1);
    add(4'b0101, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 1);
    add(4'b0101, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 1);
    add(4'b0101, 1, 1, 2'd0,  0, 2'd0,  1, 2'd0,  0, 0);
    add(4'b0101, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    add(4'b0100, 1, 0, 2'd0,  1, 2'd2,  0, 2'd0,  0, 1);
    add(4'b0100, 1, 0, 2'd0,  0, 2'd2,  0, 2'd0,  0, 1);
    add(4'b0100, 1, 0, 2'd0,  0, 2'd2,  0, 2'd0,  0, 1);
    add(4'b0100, 1, 0, 2'd0,  0, 2'd2,  0, 2'd0,  0, 1);
    add(4'b0100, 1, 1, 2'd2,  0, 2'd0,  1, 2'd2,  0, 0);
    add(4'b0100, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    add(4'b0000, 1, 1, 2'd2,  0, 2'd0,  0, 2'd0,  0, 0);
    // entry 3 with pointer 3, stale req masked, pointer wrapped to 0
    add(4'b1000, 1, 0, 2'd0,  1, 2'd3,  0, 2'd0,  0, 1);
    add(4'b1000, 1, 0, 2'd0,  0, 2'd3,  0, 2'd0,  0, 1);
    add(4'b1000, 1, 1, 2'd3,  0, 2'd0,  1, 2'd3,  0, 0);
    add(4'b1000, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    add(4'b1000, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    add(4'b1001, 1, 0, 2'd0,  1, 2'd0,  0, 2'd0,  0, 1);
    add(4'b1001, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 1);
    add(4'b1001, 1, 1, 2'd0,  0, 2'd0,  1, 2'd0,  0, 0);
    add(4'b0000, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    add(4'b0000, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);
    // offer held while sel_ready low and req withdrawn, then foreign done ignored
    add(4'b0010, 0, 0, 2'd0,  1, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 0, 0, 2'd0,  1, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 0, 0, 2'd0,  1, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 0, 0, 2'd0,  1, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 0, 0, 2'd0,  1, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 1, 0, 2'd0,  0, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 1, 1, 2'd2,  0, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 1, 0, 2'd0,  0, 2'd1,  0, 2'd0,  0, 1);
    add(4'b0000, 1, 1, 2'd1,  0, 2'd0,  1, 2'd1,  0, 0);
    add(4'b0000, 1, 0, 2'd0,  0, 2'd0,  0, 2'd0,  0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].rdy, vecs[i].dv, vecs[i].di);
      step();
      check($sformatf("v%0d sel_valid", i),    32'(bus.sel_valid),    32'(vecs[i].e_sv));
      check($sformatf("v%0d busy", i),         32'(bus.busy),         32'(vecs[i].e_busy));
      check($sformatf("v%0d retire_valid", i), 32'(bus.retire_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_busy)
        check($sformatf("v%0d sel_idx", i), 32'(bus.sel_idx), 32'(vecs[i].e_si));
      if (vecs[i].e_rv) begin
        check($sformatf("v%0d retire_idx", i), 32'(bus.retire_idx), 32'(vecs[i].e_ri));
        check($sformatf("v%0d retire_err", i), 32'(bus.retire_err), 32'(vecs[i].e_re));
      end
    end

    // Timeout: pointer is 2, no done -> error retire exactly TMO cycles after handshake.
    drive(4'b0100, 1'b1, 1'b0, 2'd0);
    step();
    check("tmo grant idx", 32'(bus.sel_idx), 2);
    drive(4'b0000, 1'b1, 1'b0, 2'd0);
    step();
    check("tmo busy", 32'(bus.busy), 1);
    for (int k = 1; k <= TMO; k++) begin
      step();
      check($sformatf("tmo c%0d retire_valid", k), 32'(bus.retire_valid), 32'(k == TMO));
    end
    check("tmo retire_err", 32'(bus.retire_err), 1);
    check("tmo retire_idx", 32'(bus.retire_idx), 2);
    step();
    check("tmo no irq", 32'(bus.irq), 0);
    check("tmo idle busy", 32'(bus.busy), 0);

    // Successful retire of entry 3 raises irq[3]; write-1-to-clear drops it.
    drive(4'b1000, 1'b1, 1'b0, 2'd0);
    step();
    check("irq grant idx", 32'(bus.sel_idx), 3);
    step();
    drive(4'b1000, 1'b1, 1'b1, 2'd3);
    step();
    check("irq retire_valid", 32'(bus.retire_valid), 1);
    drive(4'b0000, 1'b1, 1'b0, 2'd0);
    step();
    check("irq set", 32'(bus.irq), 32'(exp_irq));
    step();
    check("irq held", 32'(bus.irq), 32'(exp_irq));
    bus.irq_clear = 4'b1000;
    step();
    bus.irq_clear = 4'b0000;
    check("irq cleared", 32'(bus.irq), 0);

    // Reset in BUSY drops the transfer silently.
    drive(4'b0100, 1'b1, 1'b0, 2'd0);
    step();
    check("rst grant idx", 32'(bus.sel_idx), 2);
    step();
    check("rst pre busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 2'd0);
    #1;
    check_idle_outputs("midrst");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post rst c%0d retire_valid", k), 32'(bus.retire_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
